// File: rtl/fifo_uart_pkg.sv
// Shared definitions for the asynchronous UART FIFO and its read-side scheduler.
// Holds the scheduler state encoding, the default data width, and the FIFO
// geometry that the read- and write-side pointer blocks also use.
package fifo_uart_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int FIFO_DEPTH     = 8;
  localparam int FIFO_PTR_W     = 4;   // one extra bit for wrap detection

  // Read-side scheduler states, fixed 3-bit encoding
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SEND      = 3'd1,
    ST_WAIT_BUSY = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_GAP       = 3'd4
  } rd_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/fifo_rd_tx_cnt.sv
// Loadable up-counter with terminal-count compare. The scheduler shares one
// instance between the busy-rise timeout and the inter-frame gap, switching
// the terminal value with the state it is timing.
module fifo_rd_tx_cnt #(
  parameter int W = 5
) (
  input  logic         r_clk_rd,
  input  logic         r_rst_rd,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         inc,
  input  logic [W-1:0] term,
  output logic [W-1:0] count,
  output logic         tc
);

  // Count register: load wins over increment
  always_ff @(posedge r_clk_rd or negedge r_rst_rd) begin
    // NOTE: sequential state is written with <= so every flop samples the
    // pre-edge values of its neighbours regardless of process order.
    if (!r_rst_rd) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (inc) begin
      count <= count + 1'b1;
    end
  end

  assign tc = (count == term);

endmodule

// File: rtl/fifo_rd_tx_sched.sv
// Read-side scheduler for the 8-deep asynchronous UART FIFO (read clock domain).
// Pops the head word when the FIFO is non-empty, hands it to the UART TX with
// a one-cycle valid pulse, waits for the TX busy frame, then enforces an
// inter-frame gap. A missing busy rise within BUSY_TO cycles drops the byte
// and sets a sticky error flag.
// Optional: define FIFO_RD_TX_SCHED_STATS_EN to add frame/drop statistics.
module fifo_rd_tx_sched
  import fifo_uart_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int GAP_CYC    = 2,
  parameter int BUSY_TO    = 16,
  parameter int TO_W       = 5
) (
  input  logic                  r_clk_rd,
  input  logic                  r_rst_rd,
  input  logic                  en_i,
  input  logic                  fifo_empty_i,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data_i,
  output logic                  fifo_rd_inc_o,
  output logic [DATA_WIDTH-1:0] tx_data_o,
  output logic                  tx_data_valid_o,
  input  logic                  tx_busy_i,
  input  logic                  err_clr_i,
  output logic                  err_to_o,
  output logic                  active_o
`ifdef FIFO_RD_TX_SCHED_STATS_EN
  ,
  output logic [15:0]           tx_count_o,
  output logic [7:0]            drop_count_o
`endif
);

  // A zero gap would let IDLE re-sample a stale empty flag; one cycle minimum.
  localparam int GAP_EFF = max_int(GAP_CYC, 1);
  localparam logic [TO_W-1:0] BUSY_TC = TO_W'(BUSY_TO - 1);
  localparam logic [TO_W-1:0] GAP_TC  = TO_W'(GAP_EFF - 1);

  rd_state_e        state;
  rd_state_e        next_state;

  logic [TO_W-1:0]  cnt;
  logic [TO_W-1:0]  cnt_term;
  logic             cnt_tc;
  logic             cnt_load;
  logic             cnt_inc;

  logic             pop;         // IDLE -> SEND: capture head word, pulse inc
  logic             start;       // SEND -> WAIT_BUSY: pulse valid
  logic             timeout;     // busy never rose in time, byte dropped
  logic             frame_done;  // WAIT_DONE -> GAP: TX finished the frame

  // Shared timeout/gap counter
  fifo_rd_tx_cnt #(
    .W (TO_W)
  ) u_cnt (
    .r_clk_rd (r_clk_rd),
    .r_rst_rd (r_rst_rd),
    .load     (cnt_load),
    .load_val ('0),
    .inc      (cnt_inc),
    .term     (cnt_term),
    .count    (cnt),
    .tc       (cnt_tc)
  );

  // State register
  always_ff @(posedge r_clk_rd or negedge r_rst_rd) begin
    if (!r_rst_rd) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode; a pop decision is only ever taken in IDLE
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // through the case leaves it unassigned and no latch is inferred.
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (en_i && !fifo_empty_i) next_state = ST_SEND;
      end
      ST_SEND: begin
        if (!tx_busy_i) next_state = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (tx_busy_i)   next_state = ST_WAIT_DONE;
        else if (cnt_tc) next_state = ST_GAP;
      end
      ST_WAIT_DONE: begin
        if (!tx_busy_i) next_state = ST_GAP;
      end
      ST_GAP: begin
        if (cnt_tc) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Output/control decode: event strobes and counter control
  always_comb begin
    pop        = (state == ST_IDLE)      && (next_state == ST_SEND);
    start      = (state == ST_SEND)      && (next_state == ST_WAIT_BUSY);
    timeout    = (state == ST_WAIT_BUSY) && !tx_busy_i && cnt_tc;
    frame_done = (state == ST_WAIT_DONE) && !tx_busy_i;

    // Counter restarts from zero on every state change and only advances
    // while timing a wait that is still in progress.
    cnt_load   = (state != next_state);
    cnt_inc    = ((state == ST_WAIT_BUSY) || (state == ST_GAP)) && !cnt_load;
    cnt_term   = (state == ST_WAIT_BUSY) ? BUSY_TC : GAP_TC;
  end

  // Registered outputs: pulses, captured byte, sticky timeout flag
  always_ff @(posedge r_clk_rd or negedge r_rst_rd) begin
    if (!r_rst_rd) begin
      fifo_rd_inc_o   <= 1'b0;
      tx_data_valid_o <= 1'b0;
      tx_data_o       <= '0;
      err_to_o        <= 1'b0;
    end else begin
      fifo_rd_inc_o   <= pop;
      tx_data_valid_o <= start;
      if (pop) tx_data_o <= fifo_rd_data_i;
      // Setting outranks a simultaneous clear so no timeout is ever lost
      if (timeout)        err_to_o <= 1'b1;
      else if (err_clr_i) err_to_o <= 1'b0;
    end
  end

  assign active_o = (state != ST_IDLE);

`ifdef FIFO_RD_TX_SCHED_STATS_EN
  // Frame counter wraps, drop counter saturates
  always_ff @(posedge r_clk_rd or negedge r_rst_rd) begin
    if (!r_rst_rd) begin
      tx_count_o   <= '0;
      drop_count_o <= '0;
    end else begin
      if (frame_done) tx_count_o <= tx_count_o + 16'd1;
      if (timeout && (drop_count_o != 8'hFF)) drop_count_o <= drop_count_o + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_rd_tx_sched.sv
// Self-checking bench for fifo_rd_tx_sched. A transaction-level reference
// tracks which phase of a frame the scheduler should be in and predicts every
// registered output once per cycle; FIFO and UART TX behaviour are modelled
// around the DUT. Stats checks appear when FIFO_RD_TX_SCHED_STATS_EN is set.
module tb_fifo_rd_tx_sched;
  import fifo_uart_pkg::*;

  localparam int BUSY_TO = 16;
  localparam int GAP_CYC = 2;
  localparam int GAP_EFF = (GAP_CYC < 1) ? 1 : GAP_CYC;

  logic       r_clk_rd        = 1'b0;
  logic       r_rst_rd        = 1'b0;
  logic       en_i            = 1'b0;
  logic       fifo_empty_i    = 1'b1;
  logic [7:0] fifo_rd_data_i  = 8'h00;
  logic       fifo_rd_inc_o;
  logic [7:0] tx_data_o;
  logic       tx_data_valid_o;
  logic       tx_busy_i       = 1'b0;
  logic       err_clr_i       = 1'b0;
  logic       err_to_o;
  logic       active_o;
`ifdef FIFO_RD_TX_SCHED_STATS_EN
  logic [15:0] tx_count_o;
  logic [7:0]  drop_count_o;
`endif

  fifo_rd_tx_sched #(
    .DATA_WIDTH (8),
    .GAP_CYC    (GAP_CYC),
    .BUSY_TO    (BUSY_TO),
    .TO_W       (5)
  ) dut (
    .r_clk_rd        (r_clk_rd),
    .r_rst_rd        (r_rst_rd),
    .en_i            (en_i),
    .fifo_empty_i    (fifo_empty_i),
    .fifo_rd_data_i  (fifo_rd_data_i),
    .fifo_rd_inc_o   (fifo_rd_inc_o),
    .tx_data_o       (tx_data_o),
    .tx_data_valid_o (tx_data_valid_o),
    .tx_busy_i       (tx_busy_i),
    .err_clr_i       (err_clr_i),
    .err_to_o        (err_to_o),
    .active_o        (active_o)
`ifdef FIFO_RD_TX_SCHED_STATS_EN
    ,
    .tx_count_o      (tx_count_o),
    .drop_count_o    (drop_count_o)
`endif
  );

  initial forever #5 r_clk_rd = ~r_clk_rd;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // ---------------- reference model (frame phases) ----------------
  // 0 idle, 1 byte held awaiting TX ready, 2 awaiting busy rise,
  // 3 frame in flight, 4 inter-frame gap
  int         m_phase = 0;
  int         m_waited = 0;
  int         m_gap_left = 0;
  logic [7:0] m_data = 8'h00;
  bit         m_inc = 0, m_valid = 0, m_err = 0;
  int         m_txc = 0, m_drop = 0;

  // Advance the model over the clock edge just passed, using the inputs the
  // DUT saw at that edge (inputs only change after this runs).
  task automatic model_update();
    bit set_err;
    if (!r_rst_rd) begin
      m_phase = 0; m_waited = 0; m_gap_left = 0; m_data = 8'h00;
      m_inc = 0; m_valid = 0; m_err = 0; m_txc = 0; m_drop = 0;
      return;
    end
    set_err = 0;
    m_inc   = 0;
    m_valid = 0;
    case (m_phase)
      0: if (en_i && !fifo_empty_i) begin
           m_data = fifo_rd_data_i; m_inc = 1; m_phase = 1;
         end
      1: if (!tx_busy_i) begin
           m_valid = 1; m_waited = 0; m_phase = 2;
         end
      2: if (tx_busy_i) m_phase = 3;
         else begin
           m_waited++;
           if (m_waited == BUSY_TO) begin
             set_err = 1;
             if (m_drop < 255) m_drop++;
             m_phase = 4; m_gap_left = GAP_EFF;
           end
         end
      3: if (!tx_busy_i) begin
           m_txc = (m_txc + 1) % 65536;
           m_phase = 4; m_gap_left = GAP_EFF;
         end
      default: begin
        m_gap_left--;
        if (m_gap_left == 0) m_phase = 0;
      end
    endcase
    if (set_err)        m_err = 1;
    else if (err_clr_i) m_err = 0;
  endtask

  task automatic compare();
    check("inc",    fifo_rd_inc_o,   m_inc);
    check("valid",  tx_data_valid_o, m_valid);
    check("data",   tx_data_o,       m_data);
    check("err",    err_to_o,        m_err);
    check("active", active_o,        (m_phase != 0));
`ifdef FIFO_RD_TX_SCHED_STATS_EN
    check("tx_count",   tx_count_o,   m_txc);
    check("drop_count", drop_count_o, m_drop);
`endif
  endtask

  // ---------------- environment: FIFO and UART TX ----------------
  logic [7:0] fifo_q[$];
  bit         e_d1 = 1, e_d2 = 1;
  bit         push_req = 0;
  logic [7:0] push_val = 8'h00;

  int tx_rise = 2, tx_len = 10;
  bit tx_respond = 1, tx_force = 0, tx_rand = 0;
  bit tx_pend = 0;
  int tx_wait = 0, tx_hold = 0;

  // observations
  int         n_inc, n_valid, first_valid_cyc, last_valid_cyc, min_spacing;
  int         err_rise_cyc, busy_fall_cyc, idle_cyc;
  bit         err_seen, prev_err, prev_active;
  logic [7:0] valid_data[$];

  task automatic obs_reset();
    n_inc = 0; n_valid = 0; first_valid_cyc = -1; last_valid_cyc = -1;
    min_spacing = 1000000; err_rise_cyc = -1; busy_fall_cyc = -1; idle_cyc = -1;
    err_seen = 0; valid_data.delete();
  endtask

  task automatic observe();
    if (fifo_rd_inc_o) begin
      n_inc++;
      check("pop_nonempty", (fifo_q.size() > 0), 1);
      if (fifo_q.size() > 0) check("capture_head", tx_data_o, fifo_q[0]);
    end
    if (tx_data_valid_o) begin
      n_valid++;
      valid_data.push_back(tx_data_o);
      if (first_valid_cyc < 0) first_valid_cyc = cyc;
      if (last_valid_cyc >= 0 && (cyc - last_valid_cyc) < min_spacing)
        min_spacing = cyc - last_valid_cyc;
      last_valid_cyc = cyc;
    end
    if (err_to_o && !prev_err) begin
      err_rise_cyc = cyc; err_seen = 1;
    end
    if (!active_o && prev_active) idle_cyc = cyc;
    prev_err    = err_to_o;
    prev_active = active_o;
  endtask

  task automatic env_update();
    bit old_busy;
    if (fifo_rd_inc_o && fifo_q.size() > 0) fifo_q.delete(0);
    if (push_req && fifo_q.size() < FIFO_DEPTH) fifo_q.push_back(push_val);
    push_req = 0;
    // empty flag trails the queue contents by two cycles
    fifo_empty_i   = e_d2;
    e_d2           = e_d1;
    e_d1           = (fifo_q.size() == 0);
    fifo_rd_data_i = (fifo_q.size() > 0) ? fifo_q[0] : 8'h00;

    if (tx_hold > 0) tx_hold--;
    else if (tx_pend) begin
      if (tx_wait <= 1) begin tx_pend = 0; tx_hold = tx_len; end
      else tx_wait--;
    end
    if (tx_data_valid_o && tx_respond) begin
      if (tx_rand) begin
        tx_rise = ($urandom_range(0, 9) == 0) ? 18 : $urandom_range(1, 4);
        tx_len  = $urandom_range(1, 12);
      end
      tx_pend = 1; tx_wait = tx_rise;
    end
    old_busy  = tx_busy_i;
    tx_busy_i = tx_force | (tx_hold > 0);
    if (old_busy && !tx_busy_i) busy_fall_cyc = cyc;
  endtask

  task automatic step();
    @(negedge r_clk_rd);
    cyc++;
    model_update();
    compare();
    observe();
    env_update();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic push(input logic [7:0] v);
    push_val = v; push_req = 1;
    step();
  endtask

  task automatic drain(input int budget);
    int i;
    i = 0;
    while ((active_o || fifo_q.size() > 0 || !fifo_empty_i) && i < budget) begin
      step(); i++;
    end
    check("drain_in_budget", (i < budget), 1);
  endtask

  initial begin
    obs_reset();
    prev_err = 0; prev_active = 0;

    // ---- power-on reset ----
    run(3);
    check("por_inc",    fifo_rd_inc_o, 0);
    check("por_valid",  tx_data_valid_o, 0);
    check("por_data",   tx_data_o, 0);
    check("por_err",    err_to_o, 0);
    check("por_active", active_o, 0);
    #2 r_rst_rd = 1'b1;
    run(2);

    // ---- single byte ----
    obs_reset();
    en_i = 1'b1;
    push(8'hA5);
    run(60);
    check("single_inc_count",   n_inc, 1);
    check("single_valid_count", n_valid, 1);
    check("single_byte",        (valid_data.size() > 0) ? valid_data[0] : 8'hxx, 8'hA5);
    check("single_data_hold",   tx_data_o, 8'hA5);
    // busy low seen at cycle k -> GAP from k+1 -> IDLE observed GAP_EFF+1 later
    check("single_gap_to_idle", idle_cyc - busy_fall_cyc, GAP_EFF + 1);

    // ---- back-to-back, 8 words ----
    obs_reset();
    for (int i = 1; i <= 8; i++) push(8'(i));
    run(200);
    drain(100);
    check("b2b_inc_count",   n_inc, 8);
    check("b2b_valid_count", n_valid, 8);
    for (int i = 0; i < 8; i++)
      check("b2b_order", (valid_data.size() > i) ? valid_data[i] : 8'hxx, 8'(i + 1));
    check("b2b_spacing_min", (min_spacing >= tx_len + GAP_CYC + 2), 1);

    // ---- busy-rise timeout ----
    obs_reset();
    tx_respond = 0;
    push(8'h3C);
    push(8'hC3);
    for (int i = 0; i < 100 && !err_seen; i++) step();
    check("to_err_seen",    err_seen, 1);
    check("to_err_latency", err_rise_cyc - first_valid_cyc, BUSY_TO);
    run(80);
    check("to_next_byte_inc",   n_inc, 2);
    check("to_next_byte_valid", n_valid, 2);
    check("to_err_sticky", err_to_o, 1);
    err_clr_i = 1'b1;
    step();
    err_clr_i = 1'b0;
    check("to_err_cleared", err_to_o, 0);
    // clear held high across the next timeout: set must still win
    obs_reset();
    err_clr_i = 1'b1;
    push(8'h5A);
    for (int i = 0; i < 100 && !err_seen; i++) step();
    check("to_set_beats_clear", err_seen, 1);
    step();
    check("to_clear_after_set", err_to_o, 0);
    err_clr_i = 1'b0;
    drain(100);
    tx_respond = 1;

    // ---- enable / busy interlock ----
    obs_reset();
    en_i = 1'b0;
    push(8'h11);
    push(8'h22);
    run(30);
    check("en_off_no_pop",    n_inc, 0);
    check("en_off_idle",      active_o, 0);
    tx_force = 1;
    en_i     = 1'b1;
    run(10);
    check("busy_pop_once",    n_inc, 1);
    check("busy_valid_held",  n_valid, 0);
    check("busy_waits",       active_o, 1);
    tx_force = 0;
    run(4);
    check("busy_release_valid", n_valid, 1);
    drain(200);

    // ---- reset mid-SEND ----
    obs_reset();
    tx_force = 1;
    push(8'h77);
    for (int i = 0; i < 20 && n_inc == 0; i++) step();
    check("rst_reached_send", n_inc, 1);
    #2 r_rst_rd = 1'b0;
    #1;
    check("rst_mid_inc",    fifo_rd_inc_o, 0);
    check("rst_mid_valid",  tx_data_valid_o, 0);
    check("rst_mid_data",   tx_data_o, 0);
    check("rst_mid_active", active_o, 0);
    run(2);
    fifo_q.delete();
    e_d1 = 1; e_d2 = 1; fifo_empty_i = 1'b1; fifo_rd_data_i = 8'h00;
    tx_force = 0; tx_pend = 0; tx_hold = 0;
    run(2);
    #2 r_rst_rd = 1'b1;
    obs_reset();
    run(50);
    check("rst_empty_no_pop",   n_inc, 0);
    check("rst_empty_no_valid", n_valid, 0);

    // ---- three frames plus one timeout (stats) ----
    push(8'hA1);
    push(8'hA2);
    push(8'hA3);
    run(60);
    drain(100);
    tx_respond = 0;
    push(8'hA4);
    run(30);
    drain(100);
    tx_respond = 1;
    check("stats_model_frames", m_txc, 3);
    check("stats_model_drops",  m_drop, 1);
`ifdef FIFO_RD_TX_SCHED_STATS_EN
    check("stats_tx_count",   tx_count_o, 16'd3);
    check("stats_drop_count", drop_count_o, 8'd1);
`endif

    // ---- randomized traffic ----
    tx_rand = 1;
    for (int i = 0; i < 3000; i++) begin
      step();
      en_i      = ($urandom_range(0, 9) != 0);
      err_clr_i = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 5) == 0) begin
        push_val = 8'($urandom_range(0, 255));
        push_req = 1;
      end
    end
    en_i = 1'b1; err_clr_i = 1'b0;
    drain(500);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fifo_rd_tx_sched.md
Name: fifo_rd_tx_sched

Overview:
- Read-side scheduler for the 8-deep asynchronous UART FIFO. It runs in the read clock domain.
- Watches the FIFO empty flag, captures the head word, and pulses the read-increment. It then hands the byte to the UART transmitter with a valid/busy handshake.
- Enforces an inter-frame gap and a busy-rise timeout.
- Sits between the FIFO read-pointer/memory logic and the UART TX serializer.

Parameters:
- DATA_WIDTH, 8, width of FIFO word and TX byte.
- GAP_CYC, 2, idle cycles after each frame before the next pop. Effective value is max(GAP_CYC,1).
- BUSY_TO, 16, maximum cycles to wait for tx_busy_i to rise after valid.
- TO_W, 5, width of the timeout/gap counter. Must hold max(BUSY_TO,GAP_CYC).

Ports:
- r_clk_rd  in  1  read-domain clock
- r_rst_rd  in  1  asynchronous active-low reset
- en_i  in  1  scheduler enable; sampled only in IDLE
- fifo_empty_i  in  1  FIFO empty flag (registered in FIFO read logic)
- fifo_rd_data_i  in  DATA_WIDTH  FIFO memory data at current read address
- fifo_rd_inc_o  out  1  one-cycle read-increment pulse to FIFO
- tx_data_o  out  DATA_WIDTH  byte to UART TX; stable from capture until next capture
- tx_data_valid_o  out  1  one-cycle start pulse to UART TX
- tx_busy_i  in  1  UART TX frame in progress
- err_clr_i  in  1  clears err_to_o
- err_to_o  out  1  sticky busy-rise timeout flag
- active_o  out  1  high in any state other than IDLE

Behaviour:
- Reset (r_rst_rd low, async) sets these values:
  - state=IDLE and all counters 0.
  - fifo_rd_inc_o=0, tx_data_valid_o=0, tx_data_o=0.
  - err_to_o=0, active_o=0.
- Reset mid-frame abandons the byte. The FIFO is not re-popped.
- FSM states: IDLE, SEND, WAIT_BUSY, WAIT_DONE, GAP.
- IDLE:
  - If en_i=1 and fifo_empty_i=0: tx_data_o<=fifo_rd_data_i, fifo_rd_inc_o=1 for exactly this cycle, go to SEND.
  - Otherwise stay in IDLE.
- SEND:
  - If tx_busy_i=0: tx_data_valid_o=1 for one cycle, counter<=0, go to WAIT_BUSY.
  - If tx_busy_i=1 (TX still finishing an earlier frame): hold with valid low.
- WAIT_BUSY:
  - If tx_busy_i=1: go to WAIT_DONE.
  - Else if counter==BUSY_TO-1: err_to_o<=1, counter<=0, go to GAP. The byte is dropped.
  - Else counter++.
- WAIT_DONE: when tx_busy_i=0, counter<=0 and go to GAP.
- GAP: counter++. When counter==effective GAP_CYC-1, go to IDLE.
- Pop-to-empty latency:
  - The FIFO pointer path has 2 cycles of latency from inc to the updated empty flag.
  - The FSM path IDLE→SEND→WAIT_BUSY→WAIT_DONE→GAP→IDLE is at least 4 cycles, so a stale empty can never cause a double pop.
  - No extra settle state is required.
- err_to_o: set has priority over err_clr_i in the same cycle. Otherwise err_clr_i=1 clears it next cycle.
- en_i deasserted outside IDLE: the current byte completes, then the FSM parks in IDLE.
- Empty asserting while not in IDLE has no effect. A pop decision is made only in IDLE.
- active_o is a combinational decode of state!=IDLE.
- All outputs are registered except active_o.

Optional Feature:
- Macro: FIFO_RD_TX_SCHED_STATS_EN.
- With the macro defined:
  - Adds output tx_count_o [15:0], which increments once per WAIT_DONE→GAP transition (successful frame), wraps 0xFFFF→0, and resets to 0.
  - Adds output drop_count_o [7:0], which increments per timeout and saturates at 0xFF.
- Without the macro: the ports and counters are absent. Core behaviour is identical.

Decomposition:
- Shared package fifo_uart_pkg holds:
  - the state enum/localparams (IDLE=0, SEND=1, WAIT_BUSY=2, WAIT_DONE=3, GAP=4, 3-bit encoding);
  - DATA_WIDTH default;
  - FIFO depth 8 and pointer width 4, shared with the FIFO read/write blocks.
- One natural sub-module: fifo_rd_tx_cnt, a loadable up-counter with terminal-count compare, reused for both the gap and timeout counts.

Test Plan:
1. Reset/idle: assert r_rst_rd low mid-SEND → all outputs 0 within reset; release with fifo_empty_i=1 → no inc for 50 cycles.
2. Single byte:
   - Stimulus: fifo_rd_data_i=0xA5 and empty drops; TX model raises busy 2 cycles after valid and holds it 10 cycles.
   - Response: exactly one inc pulse, tx_data_o=0xA5, one valid pulse, then IDLE GAP_CYC cycles after busy falls.
3. Back-to-back:
   - Stimulus: FIFO preloaded with 8 words 0x01..0x08.
   - Response: 8 inc pulses, bytes delivered in order, no double pop.
   - Response: spacing between valids ≥ busy length + GAP_CYC + 2.
4. Timeout:
   - Stimulus: TX model never raises busy.
   - Response: err_to_o=1 exactly BUSY_TO cycles after valid, FSM continues to the next byte.
   - Response: err_clr_i pulse clears the flag; simultaneous set and clear leaves it set.
5. Enable/busy interlock:
   - Stimulus: en_i=0 with a non-empty FIFO → no pop.
   - Stimulus: en_i=1 while tx_busy_i is already high → FSM waits in SEND with valid low, then pulses valid once busy falls.
6. Stats (macro on): send 3 frames and force 1 timeout → tx_count_o=3, drop_count_o=1.
